regfile_reader: RTL

Sequential read-out engine for the processor register file. It sits on the register file's second read port during debug or halt. On a start command it walks a programmable address range, reads one register per cycle, and streams {address, data} beats over a valid/ready interface toward the debug/trace path. It completes with a one-cycle done pulse.

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/regfile_reader_if.sv | 41 ++++
 rtl/regfile_reader.sv | 95 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Register-file constants, types and the reader FSM encoding,
//               shared between the register file and its sequential reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       reg_data_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

    // Register index successor, wrapping modulo NUM_REGS even when
    // NUM_REGS is not a power of two.
    function automatic reg_addr_t next_addr(input reg_addr_t a);
        return (a == reg_addr_t'(NUM_REGS - 1)) ? '0 : a + reg_addr_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_reader_if.sv
// ============================================================================
// Module      : regfile_reader_if
// Description : Command, register-file read port and beat stream of the
//               register-file reader. master = reader, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_reader_if;
    import regfile_pkg::*;

    // command
    logic      start;
    logic      abort;
    reg_addr_t start_addr;
    reg_addr_t end_addr;
    // register file read port
    reg_addr_t ra;
    reg_data_t rd;
    // beat stream
    logic      out_valid;
    logic      out_ready;
    reg_addr_t out_addr;
    reg_data_t out_data;
    // status
    logic      busy;
    logic      done;

    modport master (
        input  start, abort, start_addr, end_addr, rd, out_ready,
        output ra, out_valid, out_addr, out_data, busy, done
    );

    modport slave (
        output start, abort, start_addr, end_addr, rd, out_ready,
        input  ra, out_valid, out_addr, out_data, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/regfile_reader.sv
// ============================================================================
// Module      : regfile_reader
// Description : Walks a programmable register range on the register file's
//               second read port and streams {address, data} beats over a
//               valid/ready interface; ends with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_reader
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    regfile_reader_if.master bus
);

    rd_state_e r_state;
    reg_addr_t r_ptr;        // next register to read; starts at start_addr
    reg_addr_t r_end;        // inclusive last register of the range
    logic      r_out_valid;
    reg_addr_t r_out_addr;
    reg_data_t r_out_data;
    logic      r_done;

    logic      w_load;

    // The single output slot may take a new beat when empty or being emptied.
    assign w_load = !r_out_valid || bus.out_ready;

    // Sequencer: range latch, pointer walk, output slot and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RD_IDLE;
            r_ptr       <= '0;
            r_end       <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RD_IDLE: begin
                    if (bus.start) begin
                        r_ptr   <= bus.start_addr;
                        r_end   <= bus.end_addr;
                        r_state <= RD_RUN;
                    end
                end
                RD_RUN: begin
                    if (bus.abort) begin
                        r_out_valid <= 1'b0;
                        r_state     <= RD_IDLE;
                    end else if (w_load) begin
                        // Value is sampled live, so earlier writes are seen.
                        r_out_data  <= bus.rd;
                        r_out_addr  <= r_ptr;
                        r_out_valid <= 1'b1;
                        if (r_ptr == r_end) begin
                            r_state <= RD_DRAIN;
                        end else begin
                            r_ptr <= next_addr(r_ptr);
                        end
                    end
                end
                RD_DRAIN: begin
                    if (bus.abort) begin
                        r_out_valid <= 1'b0;
                        r_state     <= RD_IDLE;
                    end else if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= RD_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= RD_IDLE;
                end
            endcase
        end
    end

    // Read port parks at 0 while idle; all other outputs come from registers.
    assign bus.ra        = (r_state == RD_IDLE) ? '0 : r_ptr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_state != RD_IDLE);
    assign bus.done      = r_done;

endmodule

`default_nettype wire
